// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator controller: FSM state encoding,
// operation codes understood by the external ALU, datapath widths and a
// helper that maps an FSM state to the entry-step code shown on the LEDs.
// No ports; imported by controlador_calculadora and sincroniza_botao.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package calc_pkg;

   localparam int LARGURA_NUM = 4;
   localparam int LARGURA_RES = 8;

   localparam logic [1:0] OP_NULA = 2'b00;
   localparam logic [1:0] OP_SOMA = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_MULT = 2'b11;

   typedef enum logic [2:0] {
      ESPERA_NUM1,
      ESPERA_OP,
      ESPERA_NUM2,
      CALCULA,
      MOSTRA
   } estado_t;

   // Entry step for LED decoding: calculating and showing share code 3 so
   // the user sees a single "result" step.
   function automatic logic [1:0] etapaDe(input estado_t estado);
      logic [1:0] etapa;
      case (estado)
         ESPERA_NUM1: etapa = 2'd0;
         ESPERA_OP:   etapa = 2'd1;
         ESPERA_NUM2: etapa = 2'd2;
         CALCULA:     etapa = 2'd3;
         MOSTRA:      etapa = 2'd3;
         default:     etapa = 2'd0;
      endcase
      return etapa;
   endfunction

endpackage

// File: rtl/controlador_calculadora_sincroniza_botao.sv
// ---------------------------------------------------------------------------
// sincroniza_botao
// Turns the asynchronous confirm button into a single-cycle accept event.
// The raw level goes through a two-flop synchronizer, optionally through a
// debounce filter, and then through a rising-edge detector so a held button
// yields exactly one event.
//
// Optional feature macro: CONFIRMA_DEBOUNCE_EN
//   defined   -> the synchronized level must be stable for DEBOUNCE_CICLOS
//                consecutive cycles before the filtered level follows it.
//   undefined -> no filter, DEBOUNCE_CICLOS has no effect.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active-low
//   limpa  in  synchronous clear (restarts the debounce counter, masks evt)
//   botao  in  raw asynchronous button level
//   evt    out one-cycle pulse on an accepted rising edge
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sincroniza_botao
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic limpa,
   input  logic botao,
   output logic evt
);

   logic sinc1_q;
   logic sinc2_q;
   logic nivel;
   logic anterior_q;

   // A filter length below one cycle is meaningless; this empty block only
   // exists so an invalid setting is visible in the elaborated hierarchy.
   if (DEBOUNCE_CICLOS < 1) begin : g_debounce_invalido
   end

   // Two-flop synchronizer bringing the button into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sinc1_q <= 1'b0;
         sinc2_q <= 1'b0;
      end else begin
         sinc1_q <= botao;
         sinc2_q <= sinc1_q;
      end
   end

`ifdef CONFIRMA_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

   logic [CW-1:0] contador_q;
   logic [CW-1:0] contador_d;
   logic          filtrado_q;
   logic          filtrado_d;

   // Debounce: count consecutive cycles where the synchronized level
   // disagrees with the filtered one; any agreement restarts the count, so
   // only a level held for the full window gets through.
   always_comb begin
      contador_d = '0;
      filtrado_d = filtrado_q;
      if (limpa) begin
         contador_d = '0;
      end else if (sinc2_q != filtrado_q) begin
         if (contador_q == CW'(DEBOUNCE_CICLOS - 1)) begin
            filtrado_d = sinc2_q;
            contador_d = '0;
         end else begin
            contador_d = contador_q + CW'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         contador_q <= '0;
         filtrado_q <= 1'b0;
      end else begin
         contador_q <= contador_d;
         filtrado_q <= filtrado_d;
      end
   end

   assign nivel = filtrado_q;
`else
   assign nivel = sinc2_q;
`endif

   // Remember the previous level so only a 0->1 transition makes an event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anterior_q <= 1'b0;
      end else begin
         anterior_q <= nivel;
      end
   end

   // A press landing together with a clear is consumed by the clear.
   assign evt = nivel & ~anterior_q & ~limpa;

endmodule

// File: rtl/controlador_calculadora.sv
// ---------------------------------------------------------------------------
// controlador_calculadora
// FSM sequencer for the calculator datapath. Collects operand 1, the
// operation and operand 2 from a shared 4-bit switch input, one value per
// confirm press, feeds them to an external combinational ALU, registers the
// 8-bit ALU result and holds it for display.
//
// Optional feature macro: CONFIRMA_DEBOUNCE_EN (debounce on confirma,
// window set by DEBOUNCE_CICLOS).
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous reset, active-low
//   entrada[3:0]   in   operand 0..15, or op code in [1:0] during op step
//   confirma       in   confirm button, asynchronous level
//   limpa          in   synchronous clear, highest priority after reset
//   resultado_ula  in   combinational ALU result for num1/num2/operacao
//   num1[3:0]      out  registered operand 1
//   num2[3:0]      out  registered operand 2
//   operacao[1:0]  out  registered op: 01 add, 10 sub, 11 mult
//   resultado[7:0] out  registered result
//   valido         out  resultado holds a fresh result
//   negativo       out  subtraction result with bit 7 set
//   erro           out  one-cycle pulse on a rejected op entry
//   etapa[1:0]     out  entry step: 0 num1, 1 op, 2 num2, 3 calc/show
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module controlador_calculadora
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [LARGURA_NUM-1:0] entrada,
   input  logic                   confirma,
   input  logic                   limpa,
   input  logic [LARGURA_RES-1:0] resultado_ula,
   output logic [LARGURA_NUM-1:0] num1,
   output logic [LARGURA_NUM-1:0] num2,
   output logic [1:0]             operacao,
   output logic [LARGURA_RES-1:0] resultado,
   output logic                   valido,
   output logic                   negativo,
   output logic                   erro,
   output logic [1:0]             etapa
);

   logic evt;

   estado_t                estado_q,    estado_d;
   logic [LARGURA_NUM-1:0] num1_q,      num1_d;
   logic [LARGURA_NUM-1:0] num2_q,      num2_d;
   logic [1:0]             operacao_q,  operacao_d;
   logic [LARGURA_RES-1:0] resultado_q, resultado_d;
   logic                   valido_q,    valido_d;
   logic                   negativo_q,  negativo_d;
   logic                   erro_q,      erro_d;

   sincroniza_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
   ) u_sincroniza_botao (
      .clk   (clk),
      .rst_n (rst_n),
      .limpa (limpa),
      .botao (confirma),
      .evt   (evt)
   );

   // State and datapath registers; all outputs come straight from here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= ESPERA_NUM1;
         num1_q      <= '0;
         num2_q      <= '0;
         operacao_q  <= OP_NULA;
         resultado_q <= '0;
         valido_q    <= 1'b0;
         negativo_q  <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         num1_q      <= num1_d;
         num2_q      <= num2_d;
         operacao_q  <= operacao_d;
         resultado_q <= resultado_d;
         valido_q    <= valido_d;
         negativo_q  <= negativo_d;
         erro_q      <= erro_d;
      end
   end

   // Next-state logic. limpa beats everything, including a simultaneous
   // press. CALCULA spends one cycle so the ALU sees settled registered
   // operands before its result is captured; presses there are dropped.
   // Leaving MOSTRA clears everything except resultado, which stays on
   // display until the next calculation overwrites it.
   always_comb begin
      estado_d    = estado_q;
      num1_d      = num1_q;
      num2_d      = num2_q;
      operacao_d  = operacao_q;
      resultado_d = resultado_q;
      valido_d    = valido_q;
      negativo_d  = negativo_q;
      erro_d      = 1'b0;

      if (limpa) begin
         estado_d    = ESPERA_NUM1;
         num1_d      = '0;
         num2_d      = '0;
         operacao_d  = OP_NULA;
         resultado_d = '0;
         valido_d    = 1'b0;
         negativo_d  = 1'b0;
      end else begin
         case (estado_q)
            ESPERA_NUM1: begin
               if (evt) begin
                  num1_d   = entrada;
                  estado_d = ESPERA_OP;
               end
            end
            ESPERA_OP: begin
               if (evt) begin
                  if (entrada[1:0] == OP_NULA) begin
                     erro_d = 1'b1;
                  end else begin
                     operacao_d = entrada[1:0];
                     estado_d   = ESPERA_NUM2;
                  end
               end
            end
            ESPERA_NUM2: begin
               if (evt) begin
                  num2_d   = entrada;
                  estado_d = CALCULA;
               end
            end
            CALCULA: begin
               resultado_d = resultado_ula;
               valido_d    = 1'b1;
               negativo_d  = (operacao_q == OP_SUB) & resultado_ula[LARGURA_RES-1];
               estado_d    = MOSTRA;
            end
            MOSTRA: begin
               if (evt) begin
                  num1_d     = '0;
                  num2_d     = '0;
                  operacao_d = OP_NULA;
                  valido_d   = 1'b0;
                  negativo_d = 1'b0;
                  estado_d   = ESPERA_NUM1;
               end
            end
            default: begin
               estado_d = ESPERA_NUM1;
            end
         endcase
      end
   end

   assign num1      = num1_q;
   assign num2      = num2_q;
   assign operacao  = operacao_q;
   assign resultado = resultado_q;
   assign valido    = valido_q;
   assign negativo  = negativo_q;
   assign erro      = erro_q;
   assign etapa     = etapaDe(estado_q);

endmodule

// File: tb/tb_controlador_calculadora.sv
// ---------------------------------------------------------------------------
// tb_controlador_calculadora
// Self-checking bench for controlador_calculadora. Contains a stand-in ALU
// and a reference model that tracks the expected entry step and register
// contents press by press, using plain integer arithmetic for results.
// Honours CONFIRMA_DEBOUNCE_EN (adds the filter window to the latency).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_controlador_calculadora;

   localparam int D = 16;
`ifdef CONFIRMA_DEBOUNCE_EN
   localparam int LAT     = 3 + D;
   localparam int RELEASE = D + 4;
`else
   localparam int LAT     = 3;
   localparam int RELEASE = 4;
`endif
   localparam int HOLD = LAT + 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] entrada;
   logic       confirma;
   logic       limpa;
   logic [7:0] resultado_ula;
   logic [3:0] num1;
   logic [3:0] num2;
   logic [1:0] operacao;
   logic [7:0] resultado;
   logic       valido;
   logic       negativo;
   logic       erro;
   logic [1:0] etapa;

   int total = 0;
   int bad   = 0;

   int mStage, mNum1, mNum2, mOp, mRes, mValid, mNeg;

   controlador_calculadora #(
      .DEBOUNCE_CICLOS(D)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .entrada       (entrada),
      .confirma      (confirma),
      .limpa         (limpa),
      .resultado_ula (resultado_ula),
      .num1          (num1),
      .num2          (num2),
      .operacao      (operacao),
      .resultado     (resultado),
      .valido        (valido),
      .negativo      (negativo),
      .erro          (erro),
      .etapa         (etapa)
   );

   always #5 clk = ~clk;

   // Stand-in for the external combinational ALU.
   always_comb begin
      resultado_ula = 8'h00;
      case (operacao)
         2'b01: resultado_ula = {4'h0, num1} + {4'h0, num2};
         2'b10: resultado_ula = {4'h0, num1} - {4'h0, num2};
         2'b11: resultado_ula = {4'h0, num1} * {4'h0, num2};
         default: resultado_ula = 8'h00;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mStage = 0; mNum1 = 0; mNum2 = 0; mOp = 0; mRes = 0; mValid = 0; mNeg = 0;
   endtask

   // Expected effect of one accepted press, straight from the entry rules.
   task automatic modelPress(input int v, output bit expErr);
      expErr = 1'b0;
      case (mStage)
         0: begin mNum1 = v; mStage = 1; end
         1: begin
            if (v % 4 == 0) expErr = 1'b1;
            else begin mOp = v % 4; mStage = 2; end
         end
         2: begin
            mNum2 = v;
            if (mOp == 1) mRes = (mNum1 + mNum2) % 256;
            else if (mOp == 2) mRes = (mNum1 - mNum2 + 256) % 256;
            else mRes = mNum1 * mNum2;
            mValid = 1;
            mNeg = (mOp == 2 && mRes >= 128) ? 1 : 0;
            mStage = 3;
         end
         default: begin
            mNum1 = 0; mNum2 = 0; mOp = 0; mValid = 0; mNeg = 0; mStage = 0;
         end
      endcase
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_num1"},      8'(num1),     8'(mNum1));
      checkOutput({tag, "_num2"},      8'(num2),     8'(mNum2));
      checkOutput({tag, "_operacao"},  8'(operacao), 8'(mOp));
      checkOutput({tag, "_resultado"}, resultado,    8'(mRes));
      checkOutput({tag, "_valido"},    8'(valido),   8'(mValid));
      checkOutput({tag, "_negativo"},  8'(negativo), 8'(mNeg));
      checkOutput({tag, "_etapa"},     8'(etapa),    8'(mStage));
      checkOutput({tag, "_erro"},      8'(erro),     8'd0);
   endtask

   // One press: raise confirma at a falling edge, check the step change and
   // error pulse at the expected latency, hold, release, check everything.
   task automatic applyStimulus(input logic [3:0] v, input int hold);
      int  oldStage;
      bit  expErr;
      oldStage = mStage;
      entrada  = v;
      confirma = 1'b1;
      modelPress(int'(v), expErr);
      repeat (LAT) @(negedge clk);
      checkOutput("etapa_latencia", 8'(etapa), 8'(mStage));
      checkOutput("erro_pulso", 8'(erro), 8'(expErr));
      if (oldStage == 2) checkOutput("valido_calcula", 8'(valido), 8'd0);
      @(negedge clk);
      checkOutput("erro_fim", 8'(erro), 8'd0);
      checkOutput("valido_latencia", 8'(valido), 8'(mValid));
      repeat (hold - LAT - 1) @(negedge clk);
      confirma = 1'b0;
      repeat (RELEASE) @(negedge clk);
      checkAll("press");
   endtask

   initial begin
      rst_n    = 1'b0;
      entrada  = 4'h0;
      confirma = 1'b0;
      limpa    = 1'b0;
      modelReset();
      #2;
      checkAll("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] add 7+5");
      applyStimulus(4'd7, HOLD);
      applyStimulus(4'b0001, HOLD);
      applyStimulus(4'd5, HOLD);
      checkOutput("soma_7_5", resultado, 8'h0C);
      applyStimulus(4'd0, HOLD);

      $display("[TB] sub 3-5 and 9-4");
      applyStimulus(4'd3, HOLD);
      applyStimulus(4'b0010, HOLD);
      applyStimulus(4'd5, HOLD);
      checkOutput("sub_3_5", resultado, 8'hFE);
      checkOutput("sub_3_5_neg", 8'(negativo), 8'd1);
      applyStimulus(4'd0, HOLD);
      applyStimulus(4'd9, HOLD);
      applyStimulus(4'b1110, HOLD);
      applyStimulus(4'd4, HOLD);
      checkOutput("sub_9_4", resultado, 8'h05);

      $display("[TB] mult 15*15 and clear from result");
      applyStimulus(4'd0, HOLD);
      applyStimulus(4'd15, HOLD);
      applyStimulus(4'b0011, HOLD);
      applyStimulus(4'd15, HOLD);
      checkOutput("mult_15_15", resultado, 8'hE1);
      applyStimulus(4'd6, HOLD);
      checkOutput("mostra_sai_etapa", 8'(etapa), 8'd0);

      $display("[TB] rejected op");
      applyStimulus(4'd2, HOLD);
      applyStimulus(4'b1100, HOLD);
      checkOutput("op_rejeitada_etapa", 8'(etapa), 8'd1);
      applyStimulus(4'b0001, HOLD);
      checkOutput("op_aceita", 8'(operacao), 8'd1);

      $display("[TB] limpa with confirma in num2 step");
      entrada  = 4'd6;
      confirma = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      limpa = 1'b1;
      @(negedge clk);
      modelReset();
      checkAll("limpa");
      limpa = 1'b0;
      repeat (3) @(negedge clk);
      confirma = 1'b0;
      repeat (RELEASE) @(negedge clk);
      checkAll("limpa_pos");

      $display("[TB] async reset in result step");
      applyStimulus(4'd8, HOLD);
      applyStimulus(4'b0011, HOLD);
      applyStimulus(4'd2, HOLD);
      checkOutput("mult_8_2", resultado, 8'h10);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #0.5;
      modelReset();
      checkAll("rst_async");
      #0.5;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] long hold");
      applyStimulus(4'd4, 50);
      checkOutput("hold_um_evento", 8'(etapa), 8'd1);
      applyStimulus(4'b0010, HOLD);
      applyStimulus(4'd11, HOLD);
      applyStimulus(4'd0, HOLD);

`ifdef CONFIRMA_DEBOUNCE_EN
      $display("[TB] debounce pulses");
      entrada  = 4'd9;
      confirma = 1'b1;
      repeat (10) @(negedge clk);
      confirma = 1'b0;
      repeat (D + 6) @(negedge clk);
      checkAll("pulso_curto");
      applyStimulus(4'd9, 20);
      checkOutput("pulso_longo", 8'(etapa), 8'd1);
`endif

      $display("[TB] random presses");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), HOLD);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
